// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared width defaults and FSM state encoding for the pipeline controller
package pipe_ctrl_pkg;
  localparam int DEF_XLEN = 64;
  localparam int DEF_REG_W = 5;
  localparam int DEF_CNT_W = 32;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// pipe_ctrl_hazard_detect: load-use hazard between the EX load and the ID source registers
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  output logic             hz
);
  assign hz = ex_is_load && (ex_rd != '0) &&
              ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect controller for the 5-stage pipeline with trap FSM and stall counter
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_busy,
  input  logic             mem_busy,
  input  logic             if_busy,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_redirect_pc,
  input  logic             mem_trap,
  input  logic             mem_mret,
  input  logic [XLEN-1:0]  trap_target,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic             flush_wb,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t          state, nxt;
  logic [XLEN-1:0] tgt;
  logic            hz, take;
  pipe_ctrl_hazard_detect #(.REG_W(REG_W)) u_hz (
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .hz(hz)
  );
  // a trap/mret waits behind a pending memory access and fires the cycle it drops
  assign take = (state == RUN) && (mem_trap || mem_mret) && !mem_busy;
  always_comb begin
    nxt = state;
    {stall_if, stall_id, stall_ex, stall_mem} = '0;
    {flush_id, flush_ex, flush_mem, flush_wb} = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if (state == FLUSH) begin
      {flush_id, flush_ex, flush_mem} = '1;
      redirect_valid = 1'b1;
      redirect_pc = tgt;
      nxt = if_busy ? FLUSH : RUN;
    end else if (take) begin
      {flush_id, flush_ex, flush_mem, stall_if} = '1;
      flush_wb = mem_trap;
      nxt = FLUSH;
    end else if (mem_busy) begin
      {stall_if, stall_id, stall_ex, stall_mem, flush_wb} = '1;
    end else if (ex_busy) begin
      {stall_if, stall_id, stall_ex, flush_mem} = '1;
    end else if (ex_redirect) begin
      {flush_id, flush_ex, redirect_valid} = '1;
      redirect_pc = ex_redirect_pc;
    end else if (hz) begin
      {stall_if, stall_id, flush_ex} = '1;
    end else if (if_busy) begin
      {stall_if, flush_id} = '1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      tgt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= nxt;
      if (take) tgt <= trap_target;
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, stall_if};
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with a scoreboard queue checked by an independent negedge monitor
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_is_load, ex_busy, mem_busy, if_busy;
  logic        ex_redirect, mem_trap, mem_mret;
  logic [63:0] ex_redirect_pc, trap_target;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex, flush_mem, flush_wb, redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] stall_cnt;
  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic [63:0] pc;
    logic [31:0] cnt;
  } exp_t;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_busy(ex_busy), .mem_busy(mem_busy), .if_busy(if_busy),
    .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc), .mem_trap(mem_trap),
    .mem_mret(mem_mret), .trap_target(trap_target), .stall_if(stall_if), .stall_id(stall_id),
    .stall_ex(stall_ex), .stall_mem(stall_mem), .flush_id(flush_id), .flush_ex(flush_ex),
    .flush_mem(flush_mem), .flush_wb(flush_wb), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  // control bits: {stall_if,stall_id,stall_ex,stall_mem,flush_id,flush_ex,flush_mem,flush_wb,redirect_valid}
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e = q.pop_front();
      act = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb, redirect_valid};
      vectors++;
      if (act !== e.ctl || redirect_pc !== e.pc || stall_cnt !== e.cnt) begin
        miscompares++;
        $display("FAIL %s: ctl=%b pc=%h cnt=%0d, required ctl=%b pc=%h cnt=%0d",
                 e.name, act, redirect_pc, stall_cnt, e.ctl, e.pc, e.cnt);
      end
    end
  end
  task automatic clr();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_rs1_used, id_rs2_used, ex_is_load, ex_busy, mem_busy, if_busy} = '0;
    {ex_redirect, mem_trap, mem_mret} = '0;
    ex_redirect_pc = '0;
    trap_target = '0;
  endtask
  task automatic step(input string name, input logic [8:0] ctl, input logic [63:0] pc, input logic [31:0] cnt);
    exp_t e;
    e.name = name;
    e.ctl = ctl;
    e.pc = pc;
    e.cnt = cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    clr();
    @(posedge clk);
    #1;
    step("reset", 9'b0000_0000_0, 64'h0, 32'd0);
    rst_n = 1'b1;
    step("idle", 9'b0000_0000_0, 64'h0, 32'd0);
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1; id_rs2 = 1; id_rs2_used = 1;
    step("load_use", 9'b1100_0100_0, 64'h0, 32'd0);
    clr();
    step("load_use_after", 9'b0000_0000_0, 64'h0, 32'd1);
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1; id_rs2 = 3; id_rs2_used = 1;
    step("rd_zero", 9'b0000_0000_0, 64'h0, 32'd1);
    ex_rd = 5; id_rs1 = 5; id_rs1_used = 0;
    step("rs1_unused", 9'b0000_0000_0, 64'h0, 32'd1);
    id_rs2 = 5; id_rs2_used = 1;
    step("rs2_hz", 9'b1100_0100_0, 64'h0, 32'd1);
    mem_busy = 1; ex_busy = 1;
    step("mem_busy0", 9'b1111_0001_0, 64'h0, 32'd2);
    step("mem_busy1", 9'b1111_0001_0, 64'h0, 32'd3);
    step("mem_busy2", 9'b1111_0001_0, 64'h0, 32'd4);
    clr();
    ex_busy = 1; ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_rs1_used = 1;
    step("ex_busy", 9'b1110_0010_0, 64'h0, 32'd5);
    ex_busy = 0; ex_redirect = 1; ex_redirect_pc = 64'h8000_0040;
    step("redirect", 9'b0000_1100_1, 64'h8000_0040, 32'd6);
    clr();
    if_busy = 1;
    step("if_busy", 9'b1000_1000_0, 64'h0, 32'd6);
    clr();
    mem_trap = 1; trap_target = 64'h8000_0100;
    step("trap_take", 9'b1000_1111_0, 64'h0, 32'd7);
    mem_trap = 0; if_busy = 1; ex_redirect = 1; ex_redirect_pc = 64'h1234; trap_target = 64'h9999;
    step("flush1", 9'b0000_1110_1, 64'h8000_0100, 32'd8);
    ex_redirect = 0; mem_trap = 1;
    step("flush2", 9'b0000_1110_1, 64'h8000_0100, 32'd8);
    clr();
    step("flush3", 9'b0000_1110_1, 64'h8000_0100, 32'd8);
    step("trap_back_run", 9'b0000_0000_0, 64'h0, 32'd8);
    mem_mret = 1; mem_busy = 1; trap_target = 64'h8000_0200;
    step("mret_busy", 9'b1111_0001_0, 64'h0, 32'd8);
    mem_busy = 0;
    step("mret_take", 9'b1000_1110_0, 64'h0, 32'd9);
    mem_mret = 0; if_busy = 1; trap_target = 64'h0;
    step("mret_flush", 9'b0000_1110_1, 64'h8000_0200, 32'd10);
    rst_n = 1'b0;
    step("async_reset", 9'b1000_1000_0, 64'h0, 32'd0);
    clr();
    rst_n = 1'b1;
    step("post_reset", 9'b0000_0000_0, 64'h0, 32'd0);
    if_busy = 1;
    step("post_if_busy", 9'b1000_1000_0, 64'h0, 32'd0);
    clr();
    step("final_cnt", 9'b0000_0000_0, 64'h0, 32'd1);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
